flp_sig_add_norm_round: RTL

Parametrised back-end of the floating-point adder. It takes operands that are already exponent-aligned and produces the final IEEE-754-style result, with these features:
- significand add/subtract, leading-zero normalisation and subnormal handling;
- guard/round/sticky rounding under four runtime rounding modes;
- overflow and inexact flags;
- valid/ready backpressure.

It sits directly after the alignment stage. Its output feeds the NTT butterfly datapath.

---
 rtl/flp_sig_add_norm_round_pkg.sv | 48 ++++
 rtl/flp_sig_add_norm_round_if.sv | 34 +++
 rtl/flp_sig_add_norm_round_lzc.sv | 20 ++
 rtl/flp_sig_add_norm_round.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/flp_sig_add_norm_round_pkg.sv
// Shared types and helpers for the floating-point adder back-end:
// rounding modes, per-stage payload structs and the rounding-increment decision.
package flp_sig_add_norm_round_pkg;

  localparam int GRS_BITS = 3;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  // Per-beat control that rides alongside the datapath through every stage.
  typedef struct packed {
    logic sign;
    logic signs_equal;
    rm_e  rm;
    logic bypass;
  } beat_ctrl_t;

  // Sum classification produced by S3 and consumed by S4/S5.
  typedef struct packed {
    logic carry;
    logic zero;
  } sum_flags_t;

  typedef struct packed {
    logic lsb;
    logic g;
    logic r;
    logic s;
  } round_bits_t;

  function automatic logic round_inc(input rm_e rm, input logic sign, input round_bits_t rb);
    logic any_dropped;
    logic inc;
    any_dropped = rb.g | rb.r | rb.s;
    unique case (rm)
      RM_RNE:  inc = rb.g & (rb.r | rb.s | rb.lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & any_dropped;
      default: inc = sign & any_dropped;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/flp_sig_add_norm_round_if.sv
// Beat interface between the alignment stage, the add/normalise/round back-end
// and its consumer.
interface flp_sig_add_norm_round_if #(
  parameter int EXP_BITS = 8,
  parameter int SIG_BITS = 23
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_sign;
  logic                         in_signs_equal;
  logic [EXP_BITS-1:0]          in_exp_b;
  logic [SIG_BITS:0]            in_sig_b;
  logic [SIG_BITS+3:0]          in_sig_a;
  logic [1:0]                   in_rm;
  logic                         in_bypass;
  logic [EXP_BITS+SIG_BITS:0]   in_bypass_value;
  logic                         out_valid;
  logic                         out_ready;
  logic [EXP_BITS+SIG_BITS:0]   out_result;
  logic                         out_overflow;
  logic                         out_inexact;

  modport master (
    output in_valid, in_sign, in_signs_equal, in_exp_b, in_sig_b, in_sig_a,
           in_rm, in_bypass, in_bypass_value, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_signs_equal, in_exp_b, in_sig_b, in_sig_a,
           in_rm, in_bypass, in_bypass_value, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_inexact
  );
endinterface

// File: rtl/flp_sig_add_norm_round_lzc.sv
// Leading-zero counter; empty flags an all-zero input (cnt is then don't-care).
module flp_sig_add_norm_round_lzc #(
  parameter int BITWIDTH = 27
) (
  input  logic [BITWIDTH-1:0]         data,
  output logic [$clog2(BITWIDTH)-1:0] cnt,
  output logic                        empty
);
  localparam int CNT_BITS = $clog2(BITWIDTH);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      if (data[i]) cnt = CNT_BITS'(BITWIDTH - 1 - i);
    end
  end

  assign empty = ~|data;
endmodule

// File: rtl/flp_sig_add_norm_round.sv
// Floating-point adder back-end: add/subtract aligned significands, normalise,
// round, flag overflow/inexact; five stages sharing one stall enable.
module flp_sig_add_norm_round
  import flp_sig_add_norm_round_pkg::*;
#(
  parameter int EXP_BITS = 8,
  parameter int SIG_BITS = 23
) (
  input logic                  clk,
  input logic                  rst_n,
  flp_sig_add_norm_round_if.slave bus
);
  localparam int LZC_BITS = $clog2(SIG_BITS + 4);
  localparam int SUM_W    = SIG_BITS + 5;
  localparam int NRM_W    = SIG_BITS + 4;
  localparam int EXT_W    = EXP_BITS + 1;
  localparam int RES_W    = 1 + EXP_BITS + SIG_BITS;
  localparam logic [EXT_W-1:0] EXP_MAX = {1'b0, {EXP_BITS{1'b1}}};

  logic       en;
  logic [5:1] vld;

  assign en           = !vld[5] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = vld[5];

  // NOTE: sequential state uses non-blocking assignments so all stages advance from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld <= '0;
    else if (en) vld <= {vld[4:1], bus.in_valid};
  end

  // ---------------- S1: conditional negation of the smaller operand
  beat_ctrl_t         ctrl_in;
  logic [SUM_W-1:0]   a_ext;
  assign ctrl_in = '{sign: bus.in_sign, signs_equal: bus.in_signs_equal,
                     rm: rm_e'(bus.in_rm), bypass: bus.in_bypass};
  assign a_ext   = {1'b0, bus.in_sig_a};

  logic [SUM_W-1:0]    s1_a;
  logic [SIG_BITS:0]   s1_b;
  logic [SUM_W-1:0]    s2_sum, s3_sum;
  logic [EXP_BITS-1:0] s1_exp, s2_exp, s3_exp;
  logic [LZC_BITS-1:0] s3_lz;
  sum_flags_t          s3_flags;
  logic [NRM_W-1:0]    s4_m;
  logic [EXT_W-1:0]    s4_exp;
  logic                s4_ovf, s4_zero;
  beat_ctrl_t          s1_ctrl, s2_ctrl, s3_ctrl, s4_ctrl;
  logic [RES_W-1:0]    s1_bval, s2_bval, s3_bval, s4_bval;

  logic [LZC_BITS-1:0] lz;
  logic                lz_empty;

  flp_sig_add_norm_round_lzc #(.BITWIDTH(SIG_BITS + 4)) u_lzc (
    .data  (s2_sum[NRM_W-1:0]),
    .cnt   (lz),
    .empty (lz_empty)
  );

  // ---------------- S4 combinational normalisation
  logic [NRM_W-1:0]    norm_m;
  logic [EXT_W-1:0]    norm_exp;
  logic [EXP_BITS-1:0] sub_shift;
  logic                norm_ovf;

  assign sub_shift = (s3_exp == '0) ? '0 : s3_exp - EXP_BITS'(1);

  always_comb begin
    norm_m   = s3_sum[NRM_W-1:0];
    norm_exp = '0;
    if (s3_flags.carry) begin
      norm_m    = s3_sum[SUM_W-1:1];
      norm_m[0] = s3_sum[1] | s3_sum[0];
      norm_exp  = EXT_W'(s3_exp) + EXT_W'(1);
    end else if (32'(s3_exp) > 32'(s3_lz)) begin
      norm_m   = s3_sum[NRM_W-1:0] << s3_lz;
      norm_exp = EXT_W'(s3_exp) - EXT_W'(s3_lz);
    end else begin
      // Subnormal: stop shifting where the exponent bottoms out at the minimum.
      norm_m   = s3_sum[NRM_W-1:0] << sub_shift;
      norm_exp = '0;
    end
  end

  assign norm_ovf = norm_exp >= EXP_MAX;

  // NOTE: datapath payload has no reset; only valid bits and outputs need a defined reset value.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_a     <= bus.in_signs_equal ? a_ext : (~a_ext + SUM_W'(1));
      s1_b     <= bus.in_sig_b;
      s1_exp   <= bus.in_exp_b;
      s1_ctrl  <= ctrl_in;
      s1_bval  <= bus.in_bypass_value;

      s2_sum   <= s1_a + {1'b0, s1_b, {GRS_BITS{1'b0}}};
      s2_exp   <= s1_exp;
      s2_ctrl  <= s1_ctrl;
      s2_bval  <= s1_bval;

      s3_sum         <= s2_sum;
      s3_lz          <= lz;
      s3_flags.carry <= s2_sum[SUM_W-1];
      s3_flags.zero  <= lz_empty && !s2_sum[SUM_W-1];
      s3_exp         <= s2_exp;
      s3_ctrl        <= s2_ctrl;
      s3_bval        <= s2_bval;

      s4_m     <= norm_m;
      s4_exp   <= norm_exp;
      s4_ovf   <= norm_ovf;
      s4_zero  <= s3_flags.zero;
      s4_ctrl  <= s3_ctrl;
      s4_bval  <= s3_bval;
    end
  end

  // ---------------- S5 rounding and result selection
  round_bits_t         rb;
  logic                inc, dropped;
  logic [SIG_BITS+1:0] rnd;
  logic [EXT_W-1:0]    rnd_exp;
  logic [SIG_BITS-1:0] rnd_frac;
  logic                rnd_ovf, to_inf, zero_sign;
  logic [RES_W-1:0]    res_d;
  logic                ovf_d, inx_d;

  assign rb      = '{lsb: s4_m[GRS_BITS], g: s4_m[2], r: s4_m[1], s: s4_m[0]};
  assign inc     = round_inc(s4_ctrl.rm, s4_ctrl.sign, rb);
  assign dropped = rb.g | rb.r | rb.s;
  assign rnd     = {1'b0, s4_m[NRM_W-1:GRS_BITS]} + (SIG_BITS + 2)'(inc);

  always_comb begin
    rnd_exp  = s4_exp;
    rnd_frac = rnd[SIG_BITS-1:0];
    if (rnd[SIG_BITS+1]) begin
      rnd_exp  = s4_exp + EXT_W'(1);
      rnd_frac = '0;
    end else if (s4_exp == '0 && rnd[SIG_BITS]) begin
      rnd_exp = EXT_W'(1);
    end
  end

  assign rnd_ovf   = s4_ovf || (rnd_exp >= EXP_MAX);
  assign to_inf    = (s4_ctrl.rm == RM_RNE) ||
                     (s4_ctrl.rm == RM_RUP && !s4_ctrl.sign) ||
                     (s4_ctrl.rm == RM_RDN &&  s4_ctrl.sign);
  assign zero_sign = s4_ctrl.signs_equal ? s4_ctrl.sign : (s4_ctrl.rm == RM_RDN);

  always_comb begin
    res_d = {s4_ctrl.sign, rnd_exp[EXP_BITS-1:0], rnd_frac};
    ovf_d = 1'b0;
    inx_d = dropped;
    if (s4_ctrl.bypass) begin
      res_d = s4_bval;
      inx_d = 1'b0;
    end else if (s4_zero) begin
      res_d = {zero_sign, {(RES_W-1){1'b0}}};
      inx_d = 1'b0;
    end else if (rnd_ovf) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      res_d = to_inf ? {s4_ctrl.sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}}
                     : {s4_ctrl.sign, {{(EXP_BITS-1){1'b1}}, 1'b0}, {SIG_BITS{1'b1}}};
    end
  end

  logic [RES_W-1:0] out_result_q;
  logic             out_overflow_q, out_inexact_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_inexact_q  <= 1'b0;
    end else if (en) begin
      out_result_q   <= res_d;
      out_overflow_q <= ovf_d;
      out_inexact_q  <= inx_d;
    end
  end

  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_inexact  = out_inexact_q;
endmodule
